instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Write-side counterpart of the word-addressed instruction memory: receives a program as a
//  byte stream (valid/ready), packs each 4 bytes into a 32-bit instruction word, and issues
//  one-cycle write strobes at byte addresses BASE_ADDR+4*n (the memory indexes by addr/4).
//  Sits between the test/boot host and the instruction memory write port; busy_o holds the CPU.
// PARAMETERS
//  DEPTH      65        instruction memory size in 32-bit words; max legal program length
//  BASE_ADDR  32'h0     byte address of the first word written (word-aligned)
// PORTS
//  clk_i         in   1   clock, all logic on rising edge
//  rst_i         in   1   synchronous reset, active-low
//  start_i       in   1   begin load; sampled in IDLE or DONE only
//  len_i         in   16  program length in words; sampled on the accepted start_i
//  byte_i        in   8   stream byte
//  byte_valid_i  in   1   byte_i valid
//  byte_ready_o  out  1   loader can accept byte_i this cycle
//  we_o          out  1   instruction memory write strobe (one cycle per word)
//  waddr_o       out  32  byte address of the word being written
//  wdata_o       out  32  instruction word being written
//  busy_o        out  1   load in progress (CPU must be held in reset/stall)
//  done_o        out  1   load finished; level, held until next accepted start_i
//  err_o         out  1   len_i > DEPTH on last start; level, cleared on next accepted start_i
// BEHAVIOUR
//  - Reset (rst_i==0 at a rising edge): state IDLE; byte_ready_o, we_o, busy_o, done_o, err_o = 0;
//    waddr_o = wdata_o = 0; word index and byte counter = 0. Reset mid-load discards the partial
//    word and issues no further writes; words already written stay in memory.
//  - FSM: IDLE -> LOAD on start_i (len_i in 1..DEPTH); IDLE -> DONE on start_i with len_i==0
//    (done_o=1, no writes) or len_i>DEPTH (done_o=1, err_o=1, no writes).
//    LOAD -> WRITE on the cycle after the 4th byte of a word is accepted.
//    WRITE -> LOAD if (index+1) < len, else -> DONE. DONE -> same transitions as IDLE on start_i.
//  - start_i is ignored in LOAD and WRITE.
//  - LOAD: byte_ready_o=1, busy_o=1. A byte is accepted when byte_valid_i && byte_ready_o.
//    Big-endian packing: 1st byte -> wdata[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
//  - WRITE (exactly one cycle): we_o=1, byte_ready_o=0, busy_o=1,
//    waddr_o = BASE_ADDR + 4*index (32-bit, no wrap check beyond DEPTH rule), wdata_o = packed word.
//    Index increments at the end of WRITE.
//  - we_o=1 only in WRITE; waddr_o/wdata_o hold their last values otherwise.
//  - Throughput: back-to-back valid bytes give 5 cycles per word (4 accept + 1 write).
//  - byte_valid_i gaps stall LOAD indefinitely; there is no timeout.
//  - Bytes presented outside LOAD are not accepted (byte_ready_o=0).
//  - DONE: busy_o=0, done_o=1, byte_ready_o=0 until the next accepted start_i, which clears
//    done_o and err_o, zeroes index and byte counter, and re-samples len_i.
// TESTING
//  1. Reset, start_i with len_i=2; stream 8'h20,08,00,05,8'h01,02,03,04 continuously
//     -> we_o at cycles 5 and 10 after the first accept with (0,32'h20080005) and
//     (4,32'h01020304); done_o=1, busy_o=0 afterward.
//  2. len_i=1 with byte_valid_i toggling every other cycle -> single write of the correct word;
//     byte_ready_o stays 1 through the gaps; we_o occurs 1 cycle after the 4th accept.
//  3. len_i=0 -> done_o=1 next cycle, we_o never asserted. len_i=66 (DEPTH=65)
//     -> done_o=1 and err_o=1, no writes.
//  4. rst_i=0 after 2 bytes of word 1 -> all outputs 0 next cycle, no we_o; new start_i with
//     len_i=1 reloads from address BASE_ADDR.
//  5. start_i pulsed during LOAD -> ignored, len unchanged. Load len_i=65 -> last write at
//     waddr_o=256 (word index 64), then DONE.
//  6. From DONE, start_i with len_i=1 -> done_o/err_o cleared, write goes to waddr_o=BASE_ADDR.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// 5 cycles/word at full rate (4 accepts + 1 write strobe); byte_ready_o drops during the write and outside a load.
module instr_mem_loader #(
    parameter int unsigned DEPTH     = 65,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] len_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t      state;
    logic [15:0] idx;
    logic [15:0] len_q;
    logic [1:0]  bcnt;
    logic [23:0] partial;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            len_q        <= '0;
            bcnt         <= '0;
            partial      <= '0;
            byte_ready_o <= 1'b0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            wdata_o      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            we_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        idx     <= '0;
                        bcnt    <= '0;
                        len_q   <= len_i;
                        done_o  <= 1'b0;
                        err_o   <= 1'b0;
                        if (len_i == 16'd0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (32'(len_i) > DEPTH) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            state        <= LOAD;
                            busy_o       <= 1'b1;
                            byte_ready_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (byte_valid_i) begin
                        partial <= {partial[15:0], byte_i};
                        bcnt    <= bcnt + 2'd1;
                        // Fourth byte completes the word: strobe it out next cycle.
                        if (bcnt == 2'd3) begin
                            state        <= WRITE;
                            byte_ready_o <= 1'b0;
                            we_o         <= 1'b1;
                            waddr_o      <= BASE_ADDR + {14'd0, idx, 2'b00};
                            wdata_o      <= {partial, byte_i};
                        end
                    end
                end
                WRITE: begin
                    idx <= idx + 16'd1;
                    if ((idx + 16'd1) < len_q) begin
                        state        <= LOAD;
                        byte_ready_o <= 1'b1;
                    end else begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
